// File: rtl/arm7_regfile_pkg.sv
// Shared constants for the ARM7 register file: mode encodings, physical storage layout and SPSR slots.
// Mode-based banking is compiled in only when ARM7_BANKED_REGS_EN is defined.
package arm7_regfile_pkg;

    localparam logic [4:0] MODE_USR = 5'b10000;
    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [4:0] MODE_SYS = 5'b11111;

`ifdef ARM7_BANKED_REGS_EN
    localparam int NUM_PHYS = 31;
    localparam int NUM_SPSR = 5;
`else
    localparam int NUM_PHYS = 16;
    localparam int NUM_SPSR = 1;
`endif
    localparam int PHYS_W = $clog2(NUM_PHYS);

    // Physical layout: 0..15 user bank, 16..22 FIQ r8..r14, then r13/r14 pairs for IRQ, SVC, ABT, UND.
    localparam int PHYS_FIQ_OFFSET = 8;
    localparam int PHYS_IRQ_BASE   = 23;
    localparam int PHYS_SVC_BASE   = 25;
    localparam int PHYS_ABT_BASE   = 27;
    localparam int PHYS_UND_BASE   = 29;

    typedef enum logic [2:0] {
        SLOT_FIQ  = 3'd0,
        SLOT_IRQ  = 3'd1,
        SLOT_SVC  = 3'd2,
        SLOT_ABT  = 3'd3,
        SLOT_UND  = 3'd4,
        SLOT_NONE = 3'd5
    } spsrSlot_e;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_CPSR = 32'h0000_00D3;

endpackage

// File: rtl/arm7_regfile_bank_map.sv
// Maps (mode, logical register) to a physical storage index and the current mode's SPSR slot.
// With ARM7_BANKED_REGS_EN undefined the map is flat and every exception mode shares slot 0.
module arm7_regfile_bank_map
    import arm7_regfile_pkg::*;
(
    input  logic [4:0]        mode_i,
    input  logic [3:0]        reg_i,
    output logic [PHYS_W-1:0] phys_o,
    output logic [2:0]        slot_o
);

    spsrSlot_e slot;

    always_comb begin
        phys_o = PHYS_W'(reg_i);
        slot   = SLOT_NONE;
`ifdef ARM7_BANKED_REGS_EN
        case (mode_i)
            MODE_FIQ: begin
                slot = SLOT_FIQ;
                if (reg_i >= 4'd8 && reg_i <= 4'd14) begin
                    phys_o = PHYS_W'(reg_i) + PHYS_W'(PHYS_FIQ_OFFSET);
                end
            end
            MODE_IRQ: begin
                slot = SLOT_IRQ;
                if (reg_i == 4'd13 || reg_i == 4'd14) phys_o = PHYS_W'(PHYS_IRQ_BASE) + PHYS_W'(reg_i[1]);
            end
            MODE_SVC: begin
                slot = SLOT_SVC;
                if (reg_i == 4'd13 || reg_i == 4'd14) phys_o = PHYS_W'(PHYS_SVC_BASE) + PHYS_W'(reg_i[1]);
            end
            MODE_ABT: begin
                slot = SLOT_ABT;
                if (reg_i == 4'd13 || reg_i == 4'd14) phys_o = PHYS_W'(PHYS_ABT_BASE) + PHYS_W'(reg_i[1]);
            end
            MODE_UND: begin
                slot = SLOT_UND;
                if (reg_i == 4'd13 || reg_i == 4'd14) phys_o = PHYS_W'(PHYS_UND_BASE) + PHYS_W'(reg_i[1]);
            end
            default: slot = SLOT_NONE;
        endcase
`else
        // The single shared SPSR lives in slot 0; USR, SYS and unknown encodings have none.
        case (mode_i)
            MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND: slot = SLOT_FIQ;
            default: slot = SLOT_NONE;
        endcase
`endif
    end

    assign slot_o = slot;

endmodule

// File: rtl/arm7_regfile.sv
// ARM7 register file responder: registered reads, single writes, CPSR/SPSR and SPSR->CPSR restore.
// Define ARM7_BANKED_REGS_EN for per-mode register banks and per-mode SPSRs; otherwise flat.
module arm7_regfile
    import arm7_regfile_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter logic [31:0] RESET_CPSR = DEFAULT_RESET_CPSR
)(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        reg_read_en_i,
    input  logic [3:0]  reg_read_reg_i,
    output logic [31:0] reg_read_value_o,
    input  logic        reg_write_en_i,
    input  logic [3:0]  reg_write_reg_i,
    input  logic [31:0] reg_write_value_i,
    input  logic        reg_write_restore_from_SPSR_i,
    input  logic        cpsr_write_en_i,
    input  logic [31:0] cpsr_write_value_i,
    input  logic        spsr_write_en_i,
    input  logic [31:0] spsr_write_value_i,
    output logic [31:0] cpsr_value_o,
    output logic [31:0] spsr_value_o
);

    logic [31:0]       regs_q [NUM_PHYS];
    logic [31:0]       readValue_q, readValue_d;
    logic [31:0]       cpsr_q, cpsr_d;
    logic [31:0]       spsrCur;
    logic [PHYS_W-1:0] readPhys, writePhys;
    logic [2:0]        readSlot, writeSlot;
    logic              restoreReq;

    arm7_regfile_bank_map uReadMap (
        .mode_i (cpsr_q[4:0]),
        .reg_i  (reg_read_reg_i),
        .phys_o (readPhys),
        .slot_o (readSlot)
    );

    arm7_regfile_bank_map uWriteMap (
        .mode_i (cpsr_q[4:0]),
        .reg_i  (reg_write_reg_i),
        .phys_o (writePhys),
        .slot_o (writeSlot)
    );

    assign restoreReq = reg_write_en_i && reg_write_restore_from_SPSR_i && (reg_write_reg_i == 4'd15);

`ifdef ARM7_BANKED_REGS_EN
    logic [31:0] spsr_q [NUM_SPSR];

    assign spsrCur = (readSlot == SLOT_NONE) ? 32'd0 : spsr_q[readSlot];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_SPSR; i++) spsr_q[i] <= 32'd0;
        end else if (spsr_write_en_i && writeSlot != SLOT_NONE) begin
            spsr_q[writeSlot] <= spsr_write_value_i;
        end
    end
`else
    logic [31:0] spsr_q;

    assign spsrCur = (readSlot == SLOT_NONE) ? 32'd0 : spsr_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            spsr_q <= 32'd0;
        end else if (spsr_write_en_i && writeSlot != SLOT_NONE) begin
            spsr_q <= spsr_write_value_i;
        end
    end
`endif

    // Restore outranks MSR even in USR/SYS, where it simply leaves CPSR alone.
    always_comb begin
        cpsr_d = cpsr_q;
        if (restoreReq) begin
            if (writeSlot != SLOT_NONE) cpsr_d = spsrCur;
        end else if (cpsr_write_en_i) begin
            cpsr_d = cpsr_write_value_i;
        end
    end

    assign readValue_d = reg_read_en_i ? regs_q[readPhys] : readValue_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_PHYS; i++) regs_q[i] <= 32'd0;
            regs_q[15]  <= RESET_PC;
            cpsr_q      <= RESET_CPSR;
            readValue_q <= 32'd0;
        end else begin
            if (reg_write_en_i) regs_q[writePhys] <= reg_write_value_i;
            cpsr_q      <= cpsr_d;
            readValue_q <= readValue_d;
        end
    end

    assign reg_read_value_o = readValue_q;
    assign cpsr_value_o     = cpsr_q;
    assign spsr_value_o     = spsrCur;

endmodule

// File: tb/tb_arm7_regfile.sv
// Scoreboard bench for arm7_regfile; expectations cover both the flat and ARM7_BANKED_REGS_EN builds.
module tb_arm7_regfile;

`ifdef ARM7_BANKED_REGS_EN
    localparam bit BANKED = 1'b1;
`else
    localparam bit BANKED = 1'b0;
`endif
    localparam logic [31:0] TB_RESET_PC = 32'h0000_1F00;

    localparam int KIND_READ = 0;
    localparam int KIND_CPSR = 1;
    localparam int KIND_SPSR = 2;

    typedef struct {
        int          cycle;
        int          kind;
        logic [31:0] exp;
        string       name;
    } expect_t;

    logic        clk;
    logic        rstN;
    logic        readEn;
    logic [3:0]  readReg;
    logic [31:0] readValue;
    logic        writeEn;
    logic [3:0]  writeReg;
    logic [31:0] writeValue;
    logic        restore;
    logic        cpsrWriteEn;
    logic [31:0] cpsrWriteValue;
    logic        spsrWriteEn;
    logic [31:0] spsrWriteValue;
    logic [31:0] cpsrValue;
    logic [31:0] spsrValue;

    expect_t sb[$];
    int      cycleCount = 0;
    int      checkCount = 0;
    int      passCount  = 0;

    arm7_regfile #(
        .RESET_PC   (TB_RESET_PC),
        .RESET_CPSR (32'h0000_00D3)
    ) dut (
        .clk_i                         (clk),
        .rst_ni                        (rstN),
        .reg_read_en_i                 (readEn),
        .reg_read_reg_i                (readReg),
        .reg_read_value_o              (readValue),
        .reg_write_en_i                (writeEn),
        .reg_write_reg_i               (writeReg),
        .reg_write_value_i             (writeValue),
        .reg_write_restore_from_SPSR_i (restore),
        .cpsr_write_en_i               (cpsrWriteEn),
        .cpsr_write_value_i            (cpsrWriteValue),
        .spsr_write_en_i               (spsrWriteEn),
        .spsr_write_value_i            (spsrWriteValue),
        .cpsr_value_o                  (cpsrValue),
        .spsr_value_o                  (spsrValue)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clearStrobes();
        readEn      = 1'b0;
        writeEn     = 1'b0;
        restore     = 1'b0;
        cpsrWriteEn = 1'b0;
        spsrWriteEn = 1'b0;
    endtask

    // Queue an expectation for the outputs as they stand after the upcoming edge.
    task automatic expectOut(input int kind, input logic [31:0] exp, input string name);
        expect_t e;
        e.cycle = cycleCount + 1;
        e.kind  = kind;
        e.exp   = exp;
        e.name  = name;
        sb.push_back(e);
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        @(negedge clk);
        clearStrobes();
    endtask

    task automatic doRead(input logic [3:0] r, input logic [31:0] exp, input string name);
        readEn  = 1'b1;
        readReg = r;
        expectOut(KIND_READ, exp, name);
        applyStimulus();
    endtask

    task automatic doWrite(input logic [3:0] r, input logic [31:0] v);
        writeEn    = 1'b1;
        writeReg   = r;
        writeValue = v;
        applyStimulus();
    endtask

    task automatic setCpsr(input logic [31:0] v);
        cpsrWriteEn    = 1'b1;
        cpsrWriteValue = v;
        expectOut(KIND_CPSR, v, "cpsr after MSR");
        applyStimulus();
    endtask

    task automatic idleCheck(input int kind, input logic [31:0] exp, input string name);
        expectOut(kind, exp, name);
        applyStimulus();
    endtask

    task automatic checkOutput(input expect_t e);
        logic [31:0] actual;
        case (e.kind)
            KIND_READ: actual = readValue;
            KIND_CPSR: actual = cpsrValue;
            default:   actual = spsrValue;
        endcase
        checkCount++;
        if (actual === e.exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", e.name, actual, e.exp, e.cycle);
        end
    endtask

    // Monitor: after each edge, compare every expectation that was issued for that edge.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            cycleCount++;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cycle <= cycleCount) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        clearStrobes();
        rstN = 1'b0;
        readReg = 4'd0;
        writeReg = 4'd0;
        writeValue = 32'd0;
        cpsrWriteValue = 32'd0;
        spsrWriteValue = 32'd0;

        applyStimulus();
        expectOut(KIND_READ, 32'd0, "reset read value");
        expectOut(KIND_CPSR, 32'hD3, "reset cpsr");
        expectOut(KIND_SPSR, 32'd0, "reset spsr");
        applyStimulus();
        rstN = 1'b1;

        expectOut(KIND_CPSR, 32'hD3, "cpsr after reset");
        doRead(4'd15, TB_RESET_PC, "r15 after reset");

        doWrite(4'd13, 32'h1000);
        setCpsr(32'hD2);
        doWrite(4'd13, 32'h2000);
        doRead(4'd13, 32'h2000, "irq r13");
        setCpsr(32'hD3);
        doRead(4'd13, BANKED ? 32'h1000 : 32'h2000, "svc r13");

        setCpsr(32'hD1);
        doWrite(4'd8, 32'hAA);
        setCpsr(32'hD0);
        expectOut(KIND_SPSR, 32'd0, "usr spsr");
        doRead(4'd8, BANKED ? 32'd0 : 32'hAA, "usr r8");
        setCpsr(32'hD1);
        doRead(4'd8, 32'hAA, "fiq r8");
        spsrWriteEn = 1'b1; spsrWriteValue = 32'h1234;
        idleCheck(KIND_SPSR, 32'h1234, "fiq spsr write");
        setCpsr(32'hD3);
        idleCheck(KIND_SPSR, BANKED ? 32'd0 : 32'h1234, "svc spsr view");

        spsrWriteEn = 1'b1; spsrWriteValue = 32'h10;
        idleCheck(KIND_SPSR, 32'h10, "svc spsr write");
        writeEn = 1'b1; writeReg = 4'd15; writeValue = 32'h40; restore = 1'b1;
        expectOut(KIND_SPSR, 32'd0, "spsr after return to usr");
        idleCheck(KIND_CPSR, 32'h10, "cpsr after restore");
        doRead(4'd15, 32'h40, "r15 after restore");
        spsrWriteEn = 1'b1; spsrWriteValue = 32'hFF;
        idleCheck(KIND_SPSR, 32'd0, "usr spsr write ignored");
        writeEn = 1'b1; writeReg = 4'd15; writeValue = 32'h44; restore = 1'b1;
        idleCheck(KIND_CPSR, 32'h10, "restore in usr keeps cpsr");
        doRead(4'd15, 32'h44, "r15 written in usr");
        setCpsr(32'hD3);
        idleCheck(KIND_SPSR, 32'h10, "svc spsr kept");
        writeEn = 1'b1; writeReg = 4'd2; writeValue = 32'h77; restore = 1'b1;
        idleCheck(KIND_CPSR, 32'hD3, "restore on r2 ignored");
        doRead(4'd2, 32'h77, "r2 plain write");

        doWrite(4'd3, 32'd5);
        writeEn = 1'b1; writeReg = 4'd3; writeValue = 32'd9;
        doRead(4'd3, 32'd5, "read during write");
        doRead(4'd3, 32'd9, "read after write");

        setCpsr(32'h15);
        idleCheck(KIND_SPSR, 32'd0, "unknown mode spsr");
        doRead(4'd13, BANKED ? 32'd0 : 32'h2000, "unknown mode r13");
        spsrWriteEn = 1'b1; spsrWriteValue = 32'hAB;
        applyStimulus();
        setCpsr(32'hD3);
        idleCheck(KIND_SPSR, 32'h10, "unknown mode spsr write ignored");

        setCpsr(32'h1F);
        cpsrWriteEn = 1'b1; cpsrWriteValue = 32'hD1;
        doWrite(4'd9, 32'h99);
        doRead(4'd9, BANKED ? 32'd0 : 32'h99, "fiq r9 after old-mode write");
        setCpsr(32'h1F);
        doRead(4'd9, 32'h99, "sys r9");

        setCpsr(32'hD3);
        spsrWriteEn = 1'b1; spsrWriteValue = 32'h1F;
        idleCheck(KIND_SPSR, 32'h1F, "svc spsr sys value");
        writeEn = 1'b1; writeReg = 4'd15; writeValue = 32'h80; restore = 1'b1;
        cpsrWriteEn = 1'b1; cpsrWriteValue = 32'hD7;
        idleCheck(KIND_CPSR, 32'h1F, "restore beats msr");
        doRead(4'd15, 32'h80, "r15 after restore+msr");

        rstN = 1'b0;
        writeEn = 1'b1; writeReg = 4'd0; writeValue = 32'h55;
        expectOut(KIND_READ, 32'd0, "read value after mid reset");
        expectOut(KIND_SPSR, 32'd0, "spsr after mid reset");
        idleCheck(KIND_CPSR, 32'hD3, "cpsr after mid reset");
        rstN = 1'b1;
        doRead(4'd0, 32'd0, "r0 write lost to reset");
        doRead(4'd15, TB_RESET_PC, "r15 after mid reset");

        applyStimulus();
        applyStimulus();
        checkCount++;
        if (sb.size() == 0) begin
            passCount++;
        end else begin
            $display("[TB] FAIL scoreboard drain: %0d entries left, expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
